imm_field_gen: RTL and testbench

- Dual-lane decode-side producer for the immediate path.
- Accepts a bundle of two 32-bit instruction words from fetch and extracts the raw immediate field, op_code (instr[6:2]), enable and signed/unsigned type per lane.
- Presents them through a registered, skid-buffered valid/ready stage directly to the inputs of Sign_Extender.
- Lane 0 is the older instruction.

---
 rtl/imm_field_gen.sv | 140 ++++++++++++++
 tb/tb_imm_field_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_field_gen.sv
// Dual-lane immediate field extractor feeding Sign_Extender through a
// registered, skid-buffered valid/ready stage. Lane 0 is the older instruction.
module imm_field_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0][XLEN-1:0]       in_instr,
  input  logic [1:0]                 in_lane_valid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0][XLEN-1:0]       imm_raw,
  output logic [1:0][4:0]            op_code,
  output logic [1:0]                 sign_extender_en,
  output logic [1:0]                 sign_extender_type,
  output logic [1:0]                 illegal,
  output logic [1:0]                 lane_valid_out
);

  localparam int unsigned LANES = 2;
  localparam int unsigned OPW   = 5;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [OPW-1:0]  op;
    logic            en;
    logic            typ;
    logic            ill;
    logic            lv;
  } lane_t;

  typedef lane_t [LANES-1:0] bundle_t;

  // Raw immediate extraction for one lane; fields follow the Sign_Extender input contract.
  function automatic lane_t decode(input logic [XLEN-1:0] i, input logic v);
    lane_t d;
    d = '0;
    if (v) begin
      d.lv = 1'b1;
      d.op = i[6:2];
      if (i[1:0] != 2'b11) begin
        d.ill = 1'b1;
      end else begin
        unique case (i[6:2])
          5'b01101, 5'b00101: begin
            d.imm = {i[31:12], 12'b0};
            d.en  = 1'b1;
          end
          5'b00100: begin
            d.imm = {20'b0, i[31:20]};
            d.en  = 1'b1;
            d.typ = (i[13:12] == 2'b01);
          end
          5'b00000: begin
            d.imm = {20'b0, i[31:20]};
            d.en  = 1'b1;
          end
          5'b01000: begin
            d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            d.en  = 1'b1;
          end
          5'b11011: begin
            d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            d.en  = 1'b1;
          end
          5'b11001: begin
            d.imm = {{20{i[31]}}, i[31:20]};
            d.en  = 1'b1;
          end
          5'b11000: begin
            d.imm = {19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0};
            d.en  = 1'b1;
          end
          5'b01100, 5'b11100, 5'b00011: d.ill = 1'b0;
          default:                      d.ill = 1'b1;
        endcase
      end
    end
    return d;
  endfunction

  bundle_t in_d;
  bundle_t or_q;
  bundle_t sr_q;
  logic    or_v;
  logic    sr_v;
  logic    accept_c;
  logic    consume_c;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      in_d[l] = decode(in_instr[l], in_lane_valid[l]);
    end
  end

  assign accept_c  = in_valid & ~sr_v;
  assign consume_c = or_v & out_ready;

  // Output register plus skid slot; skid is only ever filled while the output stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_v <= 1'b0;
      sr_v <= 1'b0;
      or_q <= '0;
      sr_q <= '0;
    end else if (flush) begin
      or_v <= 1'b0;
      sr_v <= 1'b0;
    end else if (consume_c && sr_v) begin
      or_q <= sr_q;
      sr_v <= 1'b0;
    end else if (accept_c && (!or_v || consume_c)) begin
      or_q <= in_d;
      or_v <= 1'b1;
    end else if (accept_c) begin
      sr_q <= in_d;
      sr_v <= 1'b1;
    end else if (consume_c) begin
      or_v <= 1'b0;
    end
  end

  assign in_ready  = ~sr_v;
  assign out_valid = or_v;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      imm_raw[l]            = or_q[l].imm;
      op_code[l]            = or_q[l].op;
      sign_extender_en[l]   = or_q[l].en;
      sign_extender_type[l] = or_q[l].typ;
      illegal[l]            = or_q[l].ill;
      lane_valid_out[l]     = or_q[l].lv;
    end
  end

endmodule

// File: tb/tb_imm_field_gen.sv
// Scoreboard bench for imm_field_gen: directed bundles push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_imm_field_gen;

  typedef struct packed {
    logic [1:0][31:0] imm;
    logic [1:0][4:0]  op;
    logic [1:0]       en;
    logic [1:0]       typ;
    logic [1:0]       ill;
    logic [1:0]       lv;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0][31:0] in_instr;
  logic [1:0]       in_lane_valid;
  logic             out_valid;
  logic             out_ready;
  logic [1:0][31:0] imm_raw;
  logic [1:0][4:0]  op_code;
  logic [1:0]       sign_extender_en;
  logic [1:0]       sign_extender_type;
  logic [1:0]       illegal;
  logic [1:0]       lane_valid_out;

  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  exp_t cur;
  logic hold_prev;

  imm_field_gen dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_instr           (in_instr),
    .in_lane_valid      (in_lane_valid),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .imm_raw            (imm_raw),
    .op_code            (op_code),
    .sign_extender_en   (sign_extender_en),
    .sign_extender_type (sign_extender_type),
    .illegal            (illegal),
    .lane_valid_out     (lane_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cur.imm = imm_raw;
    cur.op  = op_code;
    cur.en  = sign_extender_en;
    cur.typ = sign_extender_type;
    cur.ill = illegal;
    cur.lv  = lane_valid_out;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(
    input logic [31:0] im0, input logic [4:0] op0, input logic en0, input logic ty0, input logic il0,
    input logic [31:0] im1, input logic [4:0] op1, input logic en1, input logic ty1, input logic il1,
    input logic [1:0] lv);
    exp_t e;
    e.imm[0] = im0; e.op[0] = op0; e.en[0] = en0; e.typ[0] = ty0; e.ill[0] = il0;
    e.imm[1] = im1; e.op[1] = op1; e.en[1] = en1; e.typ[1] = ty1; e.ill[1] = il1;
    e.lv = lv;
    return e;
  endfunction

  // Monitor: pop on handshake, and while stalled the head of the queue must be on the bus.
  always @(negedge clk) begin
    if (rst || flush) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) chk("hold_valid", 128'(out_valid), 128'(1'b1));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bundle: got %h expected none at %0t", cur, $time);
        end else begin
          chk("bundle", 128'(cur), 128'(sb_q.pop_front()));
        end
        hold_prev = 1'b0;
      end else if (out_valid) begin
        if (sb_q.size() > 0) chk("hold_data", 128'(cur), 128'(sb_q[0]));
        hold_prev = 1'b1;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that accepted the bundle.
  task automatic send(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] lv, input exp_t e);
    int n;
    in_instr[0]   = i0;
    in_instr[1]   = i1;
    in_lane_valid = lv;
    in_valid      = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 128'(in_ready), 128'(1'b1));
    end else begin
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  exp_t ea, eb, ec, ed, ee, ef, eg, eh, ei;

  initial begin
    n_checks = 0;
    n_fail = 0;
    hold_prev = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_lane_valid = 2'b00;
    out_ready = 1'b1;

    ea = mk(32'h00000005, 5'b00100, 1'b1, 1'b0, 1'b0, 32'h12345000, 5'b01101, 1'b1, 1'b0, 1'b0, 2'b11);
    eb = mk(32'h00000003, 5'b00100, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 5'b01000, 1'b1, 1'b0, 1'b0, 2'b11);
    ec = mk(32'h00001FFC, 5'b11000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 5'b11011, 1'b1, 1'b0, 1'b0, 2'b11);
    ed = mk(32'h00000000, 5'b00100, 1'b1, 1'b0, 1'b0, 32'h00000000, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b01);
    ee = mk(32'h00000000, 5'b00100, 1'b1, 1'b0, 1'b0, 32'h00000000, 5'b00000, 1'b0, 1'b0, 1'b1, 2'b11);
    ef = mk(32'h00000000, 5'b11111, 1'b0, 1'b0, 1'b1, 32'h00000000, 5'b11100, 1'b0, 1'b0, 1'b0, 2'b11);
    eg = '0;
    eh = mk(32'hFFFFFFFC, 5'b11001, 1'b1, 1'b0, 1'b0, 32'h00000FF8, 5'b00000, 1'b1, 1'b0, 1'b0, 2'b11);
    ei = mk(32'h00001000, 5'b00101, 1'b1, 1'b0, 1'b0, 32'h00000403, 5'b00100, 1'b1, 1'b1, 1'b0, 2'b11);

    #2;
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
    chk("reset_data", 128'(cur), 128'(0));
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single bundle, one-cycle latency
    send(32'h00500093, 32'h123450B7, 2'b11, ea);
    @(negedge clk);
    chk("latency_out_valid", 128'(out_valid), 128'(1'b1));
    idle(1);
    @(negedge clk);
    chk("drained_out_valid", 128'(out_valid), 128'(1'b0));
    idle(1);

    // Back-to-back decode vectors at full throughput
    send(32'h00309093, 32'hFE112E23, 2'b11, eb);
    send(32'hFE000EE3, 32'hFFDFF0EF, 2'b11, ec);
    send(32'h00000013, 32'h00000000, 2'b01, ed);
    send(32'h00000013, 32'h00000000, 2'b11, ee);
    send(32'h0000007F, 32'h00000073, 2'b11, ef);
    send(32'h00500093, 32'h123450B7, 2'b00, eg);
    send(32'hFFC080E7, 32'hFF812283, 2'b11, eh);
    send(32'h00001517, 32'h4030D093, 2'b11, ei);
    idle(3);
    chk("throughput_drained", 128'(sb_q.size()), 128'(0));

    // Backpressure: A to output register, B to skid
    out_ready = 1'b0;
    send(32'h00500093, 32'h123450B7, 2'b11, ea);
    send(32'h00309093, 32'hFE112E23, 2'b11, eb);
    @(negedge clk);
    chk("bp_in_ready_low", 128'(in_ready), 128'(1'b0));
    chk("bp_out_valid", 128'(out_valid), 128'(1'b1));
    idle(2);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_back", 128'(in_ready), 128'(1'b1));
    @(negedge clk);
    chk("bp_out_valid_done", 128'(out_valid), 128'(1'b0));
    chk("bp_queue_empty", 128'(sb_q.size()), 128'(0));
    @(posedge clk);
    #1;

    // Flush with both slots full; bundle presented in the flush cycle is dropped
    out_ready = 1'b0;
    send(32'h00500093, 32'h123450B7, 2'b11, ea);
    send(32'h00309093, 32'hFE112E23, 2'b11, eb);
    in_instr[0] = 32'hFE000EE3;
    in_instr[1] = 32'hFFDFF0EF;
    in_lane_valid = 2'b11;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("flush_full_out_valid", 128'(out_valid), 128'(1'b0));
    chk("flush_full_in_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1;
    idle(3);

    // Flush with only the output register full while in_ready is high
    out_ready = 1'b0;
    send(32'h00500093, 32'h123450B7, 2'b11, ea);
    in_instr[0] = 32'hFE000EE3;
    in_instr[1] = 32'hFFDFF0EF;
    in_lane_valid = 2'b11;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("flush_or_out_valid", 128'(out_valid), 128'(1'b0));
    chk("flush_or_in_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1;
    idle(3);
    send(32'h00001517, 32'h4030D093, 2'b11, ei);
    idle(2);
    chk("post_flush_drained", 128'(sb_q.size()), 128'(0));

    // Asynchronous reset mid-cycle with both slots full
    out_ready = 1'b0;
    send(32'h00500093, 32'h123450B7, 2'b11, ea);
    send(32'h00309093, 32'hFE112E23, 2'b11, eb);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("async_rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("async_rst_data", 128'(cur), 128'(0));
    sb_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'hFE000EE3, 32'hFFDFF0EF, 2'b11, ec);
    idle(3);
    chk("final_queue_empty", 128'(sb_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
